// File: rtl/rank_order_emitter.sv
// Captures a sorted pixel-index vector on sort_done and streams the first NUM_SPIKES
// indexes, brightest first, as AER events over a four-phase req/ack handshake.
module rank_order_emitter #(
  parameter int IMAGE_SIZE = 5,
  parameter int INDEX_BITS = $clog2(IMAGE_SIZE),
  parameter int NUM_SPIKES = IMAGE_SIZE,
  parameter int RANK_BITS  = $clog2(IMAGE_SIZE + 1)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [INDEX_BITS-1:0] sorted_indexes [0:IMAGE_SIZE-1],
  input  logic                  sort_done,
  output logic                  aer_req,
  output logic [INDEX_BITS-1:0] aer_addr,
  input  logic                  aer_ack,
  output logic [RANK_BITS-1:0]  aer_rank,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  if (NUM_SPIKES < 1 || NUM_SPIKES > IMAGE_SIZE) begin : g_bad_num_spikes
    $error("rank_order_emitter: NUM_SPIKES must be in 1..IMAGE_SIZE");
  end

  localparam logic [RANK_BITS-1:0] LAST_RANK = RANK_BITS'(NUM_SPIKES);

  typedef enum logic [1:0] {IDLE, REQ, ACK_WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [RANK_BITS-1:0]  rank_q, rank_d;
  logic [RANK_BITS-1:0]  next_rank;
  logic [INDEX_BITS-1:0] buf_q [0:IMAGE_SIZE-1];
  logic [INDEX_BITS-1:0] buf_d [0:IMAGE_SIZE-1];
  logic [INDEX_BITS-1:0] addr_q, addr_d;
  logic [RANK_BITS-1:0]  arank_q, arank_d;
  logic                  overrun_q, overrun_d;

  assign next_rank = rank_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rank_d    = rank_q;
    buf_d     = buf_q;
    addr_d    = addr_q;
    arank_d   = arank_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (sort_done) begin
          buf_d   = sorted_indexes;
          rank_d  = '0;
          addr_d  = sorted_indexes[0];
          arank_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (aer_ack) state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (!aer_ack) begin
          rank_d = next_rank;
          if (next_rank == LAST_RANK) begin
            state_d = DONE;
          end else begin
            // Address only moves on the edge that raises aer_req.
            addr_d  = buf_q[next_rank[INDEX_BITS-1:0]];
            arank_d = next_rank;
            state_d = REQ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as a clear takes priority.
    if (clr_overrun) overrun_d = 1'b0;
    if (sort_done && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      rank_q    <= '0;
      addr_q    <= '0;
      arank_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rank_q    <= rank_d;
      addr_q    <= addr_d;
      arank_q   <= arank_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
    end
  end

  assign aer_req    = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign aer_addr   = addr_q;
  assign aer_rank   = arank_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rank_order_emitter.sv
// Directed bench for rank_order_emitter: a full-length instance and a NUM_SPIKES=2 instance.
module tb_rank_order_emitter;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [2:0] sorted_indexes [0:4];
  logic       sort_done, aer_ack, clr_overrun;
  logic       aer_req, busy, frame_done, overrun;
  logic [2:0] aer_addr, aer_rank;

  logic       t_sort_done, t_ack, t_clr;
  logic       t_req, t_busy, t_frame_done, t_overrun;
  logic [2:0] t_addr, t_rank;

  logic       scramble;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 CLK = ~CLK;

  rank_order_emitter #(.IMAGE_SIZE(5), .NUM_SPIKES(5)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .sorted_indexes(sorted_indexes), .sort_done(sort_done),
    .aer_req(aer_req), .aer_addr(aer_addr), .aer_ack(aer_ack), .aer_rank(aer_rank),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  rank_order_emitter #(.IMAGE_SIZE(5), .NUM_SPIKES(2)) u_trunc (
    .CLK(CLK), .RSTN(RSTN), .sorted_indexes(sorted_indexes), .sort_done(t_sort_done),
    .aer_req(t_req), .aer_addr(t_addr), .aer_ack(t_ack), .aer_rank(t_rank),
    .busy(t_busy), .frame_done(t_frame_done), .overrun(t_overrun), .clr_overrun(t_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (scramble)
      for (int i = 0; i < 5; i++) sorted_indexes[i] = 3'($urandom_range(0, 4));
  endtask

  task automatic set_vec(input logic [2:0] a, b, c, d, e);
    sorted_indexes[0] = a; sorted_indexes[1] = b; sorted_indexes[2] = c;
    sorted_indexes[3] = d; sorted_indexes[4] = e;
  endtask

  // Expects u_dut already in REQ; performs one ack-echo handshake.
  task automatic do_event(input logic [2:0] ea, input logic [2:0] er);
    check("req_high", aer_req, 1);
    check("addr", aer_addr, ea);
    check("rank", aer_rank, er);
    aer_ack = 1'b1;
    step();
    check("req_drop", aer_req, 0);
    check("addr_held", aer_addr, ea);
    aer_ack = 1'b0;
    step();
  endtask

  task automatic do_event_t(input logic [2:0] ea, input logic [2:0] er);
    check("t_req_high", t_req, 1);
    check("t_addr", t_addr, ea);
    check("t_rank", t_rank, er);
    t_ack = 1'b1;
    step();
    check("t_req_drop", t_req, 0);
    t_ack = 1'b0;
    step();
  endtask

  task automatic check_done_then_idle();
    check("frame_done", frame_done, 1);
    check("done_busy", busy, 1);
    check("done_req", aer_req, 0);
    step();
    check("frame_done_clr", frame_done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    RSTN = 1'b0; scramble = 1'b0;
    sort_done = 0; aer_ack = 0; clr_overrun = 0;
    t_sort_done = 0; t_ack = 0; t_clr = 0;
    set_vec(0, 0, 0, 0, 0);
    #2;
    check("rst_req", aer_req, 0);
    check("rst_addr", aer_addr, 0);
    check("rst_rank", aer_rank, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    step(); step();
    RSTN = 1'b1;
    step();

    // Basic frame
    set_vec(3, 0, 4, 1, 2);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    check("basic_busy", busy, 1);
    do_event(3, 0); do_event(0, 1); do_event(4, 2); do_event(1, 3); do_event(2, 4);
    check_done_then_idle();

    // Truncation on the NUM_SPIKES=2 instance
    t_sort_done = 1'b1;
    step();
    t_sort_done = 1'b0;
    do_event_t(3, 0); do_event_t(0, 1);
    check("t_frame_done", t_frame_done, 1);
    check("t_done_req", t_req, 0);
    step();
    check("t_idle_busy", t_busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t_no_third_req", t_req, 0);
    end

    // Stalled ack
    set_vec(1, 2, 3, 4, 0);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_req", aer_req, 1);
      check("stall_addr", aer_addr, 1);
      step();
    end
    aer_ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("ackhi_req", aer_req, 0);
      check("ackhi_addr", aer_addr, 1);
      check("ackhi_rank", aer_rank, 0);
    end
    aer_ack = 1'b0;
    step();
    do_event(2, 1); do_event(3, 2); do_event(4, 3); do_event(0, 4);
    check_done_then_idle();

    // Overrun plus input isolation
    set_vec(3, 0, 4, 1, 2);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    scramble = 1'b1;
    do_event(3, 0); do_event(0, 1);
    set_vec(2, 4, 1, 0, 3);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    check("overrun_set", overrun, 1);
    do_event(4, 2);
    sort_done = 1'b1; clr_overrun = 1'b1;
    step();
    sort_done = 1'b0;
    check("set_beats_clr", overrun, 1);
    step();
    clr_overrun = 1'b0;
    check("clr_busy", overrun, 0);
    do_event(1, 3); do_event(2, 4);
    scramble = 1'b0;
    check("done_frame_done", frame_done, 1);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    check("overrun_in_done", overrun, 1);
    check("discard_busy", busy, 0);
    check("discard_req", aer_req, 0);
    step();
    check("discard_req2", aer_req, 0);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("clr_idle", overrun, 0);

    // Reset mid-handshake
    set_vec(4, 3, 2, 1, 0);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    aer_ack = 1'b1;
    #1;
    check("pre_rst_req", aer_req, 1);
    RSTN = 1'b0;
    #1;
    check("arst_req", aer_req, 0);
    check("arst_addr", aer_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_rank", aer_rank, 0);
    step();
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aer_ack = ~aer_ack;
      step();
      check("post_rst_no_req", aer_req, 0);
      check("post_rst_idle", busy, 0);
    end
    aer_ack = 1'b0;
    set_vec(2, 1, 0, 3, 4);
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    do_event(2, 0); do_event(1, 1); do_event(0, 2); do_event(3, 3); do_event(4, 4);
    check_done_then_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rank_order_emitter.md
# rank_order_emitter

Downstream consumer of the pixel sorter. When the sorter pulses its done flag, this block captures the sorted pixel-index vector and streams the first NUM_SPIKES indexes, in rank order (brightest first), to the SNN core. Each index goes out as one AER address event over a four-phase req/ack handshake. It also reports frame completion and overrun.

## Interface
- IMAGE_SIZE, 5, number of pixels/entries in the sorted vector
- INDEX_BITS, $clog2(IMAGE_SIZE), width of one pixel index
- NUM_SPIKES, IMAGE_SIZE, number of ranks emitted per frame; legal 1..IMAGE_SIZE; elaboration-time error otherwise
- RANK_BITS, $clog2(IMAGE_SIZE+1), width of rank counter
- CLK  in  1  clock, all state updates on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- sorted_indexes  in  [INDEX_BITS-1:0] x [0:IMAGE_SIZE-1]  sorter output, entry 0 = brightest pixel
- sort_done  in  1  one-cycle pulse; sorted_indexes valid in that cycle only
- aer_req  out  1  AER request (four-phase)
- aer_addr  out  INDEX_BITS  AER address = pixel index of current rank
- aer_ack  in  1  AER acknowledge from SNN core
- aer_rank  out  RANK_BITS  rank (0-based) of event currently on aer_addr
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after last event's handshake completes
- overrun  out  1  sticky: sort_done seen while busy
- clr_overrun  in  1  synchronous clear of overrun

## Operation
- States: IDLE, REQ, ACK_WAIT, DONE. All outputs registered or decoded from the state register only; no combinational path from aer_ack to any output.
- IDLE: busy=0, aer_req=0. If sort_done=1 at an edge, copy all IMAGE_SIZE entries into an internal buffer, set rank=0, go to REQ. aer_ack ignored in IDLE.
- REQ: aer_req=1, aer_addr=buf[rank], aer_rank=rank. Stay until aer_ack=1 is sampled, then go to ACK_WAIT.
- ACK_WAIT: aer_req=0; aer_addr/aer_rank held. Stay until aer_ack=0 is sampled. Then rank<=rank+1; if rank+1==NUM_SPIKES go to DONE, else go to REQ.
- DONE: frame_done=1 for exactly this cycle, busy=1, then go to IDLE unconditionally.
- Buffer is written only in IDLE on sort_done. Later changes on sorted_indexes never affect an in-flight frame.
- overrun: set at any edge where sort_done=1 and state != IDLE (including DONE); that frame is discarded. Cleared by clr_overrun=1. Set and clear in the same cycle: set wins.
- Rank counter never exceeds NUM_SPIKES. Entries at rank >= NUM_SPIKES are never emitted.

## Timing
- Reset values: aer_req=0, aer_addr=0, aer_rank=0, busy=0, frame_done=0, overrun=0, state=IDLE, rank=0, buffer=0.
- RSTN low at any time, including mid-handshake: outputs go to reset values asynchronously. aer_req may drop while aer_ack is high; the core must tolerate this. On RSTN release the block is in IDLE and needs a fresh sort_done.
- sort_done sampled at edge t: busy=1, aer_req=1 and aer_addr=sorted_indexes[0] all valid after edge t (1-cycle latency).
- aer_ack rising, sampled at edge e: aer_req=0 after e. aer_ack falling, sampled at edge f: next aer_req=1 after f with the new address.
- aer_addr changes only on the edge that raises aer_req, so it is stable for the whole req-high/ack-high window.
- Minimum 2 cycles per event, for an ack that follows req within one cycle. A frame with an immediate-responding ack takes 2*NUM_SPIKES+1 cycles from first req to frame_done.
- The frame_done cycle is still busy. The earliest accepted next sort_done is the cycle after frame_done.

## Test plan
- Basic frame: IMAGE_SIZE=5, NUM_SPIKES=5, sorted_indexes={3,0,4,1,2}, sort_done pulse, ack echoes req after 1 cycle -> addresses 3,0,4,1,2 with ranks 0..4; frame_done one cycle after last ack falls; busy drops the next cycle.
- Truncation: NUM_SPIKES=2, same vector -> only addresses 3,0 emitted; frame_done after the second handshake; no third req.
- Slow/stalled ack: hold aer_ack low 10 cycles in REQ, then high 7 cycles -> aer_req stays high 10 cycles, aer_addr stable throughout, no advance until ack falls.
- Overrun: second sort_done with a different vector during rank 2 -> overrun=1, the in-flight frame completes with the original addresses, the new vector is never emitted. clr_overrun and sort_done together while busy -> overrun stays 1.
- Input isolation: change sorted_indexes every cycle after capture -> emitted addresses equal the values captured at sort_done.
- Reset mid-operation: drop RSTN while aer_req=1 and aer_ack=1 -> all outputs 0 immediately. After release, ack toggling alone produces no req; a new sort_done restarts at rank 0.
